// File: rtl/targ_uart_tx_param_pkg.sv
// Shared types for the parametrised UART transmitter:
// parity modes, FSM encoding and config resolvers.
package targ_uart_tx_param_pkg;

  localparam int DEFAULT_BAUD_ACC_W = 16;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_GAP,
    ST_BREAK
  } tx_state_e;

  // Out-of-range bit counts fall back to 8.
  function automatic logic [3:0] resolve_bits(
    input logic [3:0] b
  );
    return (b >= 4'd5 && b <= 4'd9) ? b : 4'd8;
  endfunction

  function automatic logic [2:0] resolve_par(
    input logic [2:0] p
  );
    return (p <= PAR_SPACE) ? p : PAR_NONE;
  endfunction

endpackage

// File: rtl/targ_uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// Head word is presented combinationally from the read pointer.
module targ_uart_tx_fifo #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/targ_uart_tx_param.sv
// UART transmitter with input FIFO, runtime frame format,
// phase-accumulator baud, idle gap and break generation.
module targ_uart_tx_param
  import targ_uart_tx_param_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_ACC_W = DEFAULT_BAUD_ACC_W,
  parameter int GAP_W      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [3:0]                  cfg_data_bits,
  input  logic [2:0]                  cfg_parity,
  input  logic                        cfg_two_stop,
  input  logic [GAP_W-1:0]            cfg_gap,
  input  logic [BAUD_ACC_W-1:0]       cfg_baud_inc,
  input  logic                        send_break,
  output logic                        TxD,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  tx_state_e             state_q;
  logic [BAUD_ACC_W-1:0] acc_q;
  logic [BAUD_ACC_W:0]   acc_sum;
  logic                  tick;
  logic [DATA_W-1:0]     word_q;
  logic [3:0]            idx_q;
  logic [3:0]            nbits_q;
  logic [2:0]            par_q;
  logic                  two_q;
  logic [GAP_W-1:0]      gap_q;
  logic [GAP_W-1:0]      gcnt_q;
  logic                  txd_q;
  logic                  txd_d;
  logic                  par_x;
  logic                  par_bit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_W-1:0]     fifo_rdata;

  targ_uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_valid),
    .pop_i   (fifo_pop),
    .wdata_i (tx_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_ready = ~fifo_full;
  assign tx_busy  = (state_q != ST_IDLE);
  assign TxD      = txd_q;

  // Break wins over queued data, so no pop while it is requested.
  assign fifo_pop = (state_q == ST_IDLE)
                  & ~send_break & ~fifo_empty;

  // The tick is the carry of the add that is about to be stored.
  assign acc_sum = {1'b0, acc_q} + {1'b0, cfg_baud_inc};
  assign tick    = acc_sum[BAUD_ACC_W];

  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < nbits_q) begin
        par_x = par_x ^ word_q[i];
      end
    end
  end

  always_comb begin
    par_bit = 1'b0;
    unique case (1'b1)
      par_q == PAR_EVEN: par_bit = par_x;
      par_q == PAR_ODD:  par_bit = ~par_x;
      par_q == PAR_MARK: par_bit = 1'b1;
      default:           par_bit = 1'b0;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_BREAK:  txd_d = 1'b0;
      ST_DATA:   txd_d = word_q[idx_q];
      ST_PARITY: txd_d = par_bit;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      nbits_q <= 4'd8;
      par_q   <= PAR_NONE;
      two_q   <= 1'b0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      txd_q <= txd_d;
      if (state_q != ST_IDLE) begin
        acc_q <= acc_sum[BAUD_ACC_W-1:0];
      end
      unique case (state_q)
        ST_IDLE: begin
          if (send_break || !fifo_empty) begin
            nbits_q <= resolve_bits(cfg_data_bits);
            par_q   <= resolve_par(cfg_parity);
            two_q   <= cfg_two_stop;
            gap_q   <= cfg_gap;
          end
          if (send_break) begin
            state_q <= ST_BREAK;
          end else if (!fifo_empty) begin
            word_q  <= fifo_rdata;
            acc_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (idx_q == nbits_q - 4'd1) begin
              state_q <= (par_q != PAR_NONE)
                       ? ST_PARITY : ST_STOP1;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (tick) begin
            gcnt_q <= gap_q;
            if (two_q) begin
              state_q <= ST_STOP2;
            end else if (gap_q != '0) begin
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          if (tick) begin
            gcnt_q  <= gap_q;
            state_q <= (gap_q != '0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gcnt_q == GAP_W'(1)) begin
              state_q <= ST_IDLE;
            end else begin
              gcnt_q <= gcnt_q - GAP_W'(1);
            end
          end
        end
        ST_BREAK: begin
          // Fresh phase so the trailing stop bit is a full bit-time.
          if (!send_break) begin
            acc_q   <= '0;
            state_q <= ST_STOP1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
